// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state encoding and sizing helper for the serial-to-parallel receiver
package sipo_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} sipo_state_t;

  localparam int SIPO_DEFAULT_N = 8;

  // The bit counter must be able to hold N itself (parity build counts past the last data bit).
  function automatic int sipo_count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - LSB-first serial-to-parallel receiver with VALID/ACK and sticky OVERRUN
// Define SIPO_PARITY_EN to expect an even-parity bit after each word and report it on PERR.
module serial_to_parallel_rx
  import sipo_pkg::*;
#(
  parameter int N = SIPO_DEFAULT_N
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         SIN,
  input  logic         EN,
  input  logic         START,
  input  logic         ACK,
  output logic [N-1:0] DATAR,
  output logic         VALID,
  output logic         BUSY,
  output logic         OVERRUN,
  output logic         PERR
);

  localparam int             CW       = sipo_count_width(N);
  localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);

  sipo_state_t   r_state;
  logic [N-1:0]  r_sr;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_datar;
  logic          r_valid;
  logic          r_overrun;
  logic          r_perr;

  logic [N-1:0]  w_shifted;
  logic [N-1:0]  w_word;
  logic          w_complete;
  logic          w_perr;
  logic          w_take;

  assign w_shifted = {SIN, r_sr[N-1:1]};

`ifdef SIPO_PARITY_EN
  assign w_complete = EN && !START && (r_state == PAR);
  assign w_word     = r_sr;
  assign w_perr     = ^{r_sr, SIN};
`else
  assign w_complete = EN && !START && (r_state == SHIFT) && (r_count == LAST_BIT);
  assign w_word     = w_shifted;
  assign w_perr     = 1'b0;
`endif

  // A finished word is only accepted if the output slot is free or being acknowledged now.
  assign w_take = w_complete && (!r_valid || ACK);

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_count <= '0;
    end else if (EN) begin
      if (START) begin
        r_sr    <= {SIN, {(N-1){1'b0}}};
        r_count <= CW'(1);
        r_state <= SHIFT;
      end else begin
        case (r_state)
          IDLE: begin
          end
          SHIFT: begin
            r_sr <= w_shifted;
            if (r_count == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
              r_count <= r_count + CW'(1);
              r_state <= PAR;
`else
              r_count <= '0;
              r_state <= IDLE;
`endif
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
          PAR: begin
            r_count <= '0;
            r_state <= IDLE;
          end
          default: begin
            r_count <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      r_datar   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else if (w_take) begin
      r_datar <= w_word;
      r_valid <= 1'b1;
      r_perr  <= w_perr;
    end else if (w_complete) begin
      r_overrun <= 1'b1;
    end else if (r_valid && ACK) begin
      r_valid <= 1'b0;
    end
  end

  assign DATAR   = r_datar;
  assign VALID   = r_valid;
  assign BUSY    = (r_state != IDLE);
  assign OVERRUN = r_overrun;
  assign PERR    = r_perr;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - directed, table-driven bench for serial_to_parallel_rx
// Parity sequences are included when SIPO_PARITY_EN is defined.
module tb_serial_to_parallel_rx;

  localparam int N = 8;
`ifdef SIPO_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         N_RESET;
  logic         SIN;
  logic         EN;
  logic         START;
  logic         ACK;
  logic [N-1:0] DATAR;
  logic         VALID;
  logic         BUSY;
  logic         OVERRUN;
  logic         PERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  serial_to_parallel_rx #(.N(N)) dut (
    .CLK(CLK), .N_RESET(N_RESET), .SIN(SIN), .EN(EN), .START(START), .ACK(ACK),
    .DATAR(DATAR), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN), .PERR(PERR)
  );

  typedef struct {
    logic [N-1:0] word;
    int           gap;
    logic         ack_after;
    logic [N-1:0] exp_datar;
    logic         exp_overrun;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n, input logic ack);
    EN = 1'b0; START = 1'b0; SIN = 1'b0; ACK = ack;
    repeat (n) tick();
    ACK = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic st, input logic ack);
    EN = 1'b1; SIN = b; START = st; ACK = ack;
    tick();
    EN = 1'b0; SIN = 1'b0; START = 1'b0; ACK = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap, input logic ack_last, input logic par_bit);
    for (int i = 0; i < N; i++) begin
      if (gap > 0 && i > 0) begin
        idle(((i - 1) % gap) + 1, 1'b0);
        check("busy_in_gap", BUSY, 1'b1);
      end
      send_bit(w[i], i == 0, ack_last && (i == N - 1) && !HAS_PAR);
    end
    if (HAS_PAR) send_bit(par_bit, 1'b0, ack_last);
  endtask

  task automatic do_reset();
    N_RESET = 1'b0;
    idle(1, 1'b0);
    N_RESET = 1'b1;
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, gap: 0, ack_after: 1'b1, exp_datar: 8'hA5, exp_overrun: 1'b0};
    vecs[1] = '{word: 8'hA5, gap: 3, ack_after: 1'b1, exp_datar: 8'hA5, exp_overrun: 1'b0};
    vecs[2] = '{word: 8'h3C, gap: 0, ack_after: 1'b0, exp_datar: 8'h3C, exp_overrun: 1'b0};
    vecs[3] = '{word: 8'hF0, gap: 1, ack_after: 1'b1, exp_datar: 8'h3C, exp_overrun: 1'b1};
    vecs[4] = '{word: 8'h5A, gap: 2, ack_after: 1'b1, exp_datar: 8'h5A, exp_overrun: 1'b1};

    N_RESET = 1'b0; SIN = 1'b0; EN = 1'b0; START = 1'b0; ACK = 1'b0;
    idle(2, 1'b0);
    check("rst_datar", DATAR, 8'h00);
    check("rst_valid", VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_overrun", OVERRUN, 1'b0);
    check("rst_perr", PERR, 1'b0);
    N_RESET = 1'b1;

    // Latency: VALID must stay low until the edge that samples the final bit.
    for (int i = 0; i < N; i++) begin
      send_bit(i == 3 ? 1'b1 : 1'b0, i == 0, 1'b0);
      if (i < N - 1 || HAS_PAR) check("lat_valid_low", VALID, 1'b0);
    end
    if (HAS_PAR) send_bit(1'b1, 1'b0, 1'b0);
    check("lat_valid_high", VALID, 1'b1);
    check("lat_datar", DATAR, 8'h08);
    check("lat_busy", BUSY, 1'b0);
    idle(1, 1'b1);
    check("lat_ack_valid", VALID, 1'b0);
    idle(1, 1'b1);
    check("ack_idle_valid", VALID, 1'b0);
    check("ack_idle_datar", DATAR, 8'h08);

    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].word, vecs[v].gap, 1'b0, ^vecs[v].word);
      check($sformatf("vec%0d_datar", v), DATAR, vecs[v].exp_datar);
      check($sformatf("vec%0d_valid", v), VALID, 1'b1);
      check($sformatf("vec%0d_busy", v), BUSY, 1'b0);
      check($sformatf("vec%0d_overrun", v), OVERRUN, vecs[v].exp_overrun);
      check($sformatf("vec%0d_perr", v), PERR, 1'b0);
      if (vecs[v].ack_after) begin
        idle(1, 1'b1);
        check($sformatf("vec%0d_ack_valid", v), VALID, 1'b0);
        check($sformatf("vec%0d_ack_datar", v), DATAR, vecs[v].exp_datar);
        check($sformatf("vec%0d_ack_overrun", v), OVERRUN, vecs[v].exp_overrun);
      end
    end

    // ACK in the completing cycle frees the slot for the new word.
    do_reset();
    send_word(8'h11, 0, 1'b0, ^8'h11);
    check("same_ack_first", DATAR, 8'h11);
    send_word(8'h22, 0, 1'b1, ^8'h22);
    check("same_ack_datar", DATAR, 8'h22);
    check("same_ack_valid", VALID, 1'b1);
    check("same_ack_overrun", OVERRUN, 1'b0);
    idle(1, 1'b1);

    // Resync: partial frame abandoned by a fresh START.
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b0);
    check("restart_busy", BUSY, 1'b1);
    send_word(8'h81, 0, 1'b0, ^8'h81);
    check("restart_datar", DATAR, 8'h81);
    check("restart_valid", VALID, 1'b1);
    check("restart_overrun", OVERRUN, 1'b0);

    // Reset mid-frame: everything cleared, trailing bits without START ignored.
    idle(1, 1'b1);
    send_word(8'h7E, 0, 1'b0, ^8'h7E);
    for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0, 1'b0);
    do_reset();
    check("midrst_datar", DATAR, 8'h00);
    check("midrst_valid", VALID, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_overrun", OVERRUN, 1'b0);
    for (int i = 0; i < N + 1; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("midrst_tail_valid", VALID, 1'b0);
    check("midrst_tail_busy", BUSY, 1'b0);

`ifdef SIPO_PARITY_EN
    send_word(8'h07, 0, 1'b0, 1'b1);
    check("par_ok_datar", DATAR, 8'h07);
    check("par_ok_perr", PERR, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < N; i++) send_bit(i < 3, i == 0, 1'b0);
    check("par_wait_valid", VALID, 1'b0);
    check("par_wait_busy", BUSY, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    check("par_bad_valid", VALID, 1'b1);
    check("par_bad_perr", PERR, 1'b1);
    check("par_bad_datar", DATAR, 8'h07);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
